// File: rtl/uart_cmd_exec.sv
// uart_cmd_exec: executes one parsed UART command at a time against a
// 256 x 32-bit register port and streams an ASCII response to the transmitter.
// Optional feature macro: UART_EXEC_TIMEOUT_EN (255-cycle MEM_ACK timeout, "TO").
module uart_cmd_exec (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    input  logic        CMD_W,
    input  logic        CMD_R,
    input  logic        CMD_FAIL,
    input  logic [15:0] CMD_ADDR,
    input  logic [63:0] CMD_DATA,
    output logic        PARSER_START,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [7:0]  MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        TX_VALID,
    output logic [7:0]  TX_DATA,
    input  logic        TX_READY,
    output logic        BUSY,
    output logic        OVERRUN
);

    typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_RESP} state_t;
    typedef enum logic [1:0] {RSP_OK, RSP_ER, RSP_TO, RSP_HEX} resp_t;

    // '0'-'9' carry the nibble in their low four bits; 'A'-'F' (0x41-0x46)
    // need +9 on the low four bits. Anything else has already been rejected
    // by the parser and simply maps to zero.
    function automatic logic [3:0] asc_to_nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)      return c[3:0];
        else if (c >= 8'h41 && c <= 8'h46) return c[3:0] + 4'd9;
        else                               return 4'h0;
    endfunction

    // Uppercase hex digit for a nibble.
    function automatic logic [7:0] nib_to_asc(input logic [3:0] n);
        if (n < 4'd10) return {4'h3, n};
        else           return {4'h4, n - 4'd9};
    endfunction

    state_t       state_q, state_d;
    resp_t        resp_q, resp_d;
    logic         we_q, we_d;
    logic [7:0]   addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [31:0]  rdata_q, rdata_d;
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   end_q, end_d;
    logic         overrun_q, overrun_d;
`ifdef UART_EXEC_TIMEOUT_EN
    logic [7:0]   cnt_q, cnt_d;
`endif

    logic [7:0]   cmd_addr;
    logic [31:0]  cmd_wdata;
    logic [31:0]  rdata_shift;
    logic [7:0]   tx_byte;

    // Convert the ASCII-hex command fields to binary, MS character first.
    always_comb begin
        cmd_addr = {asc_to_nib(CMD_ADDR[15:8]), asc_to_nib(CMD_ADDR[7:0])};
        cmd_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            cmd_wdata[4*i +: 4] = asc_to_nib(CMD_DATA[8*i +: 8]);
        end
    end

    // Select the response byte addressed by the index; CR and LF always
    // occupy the last two slots, whatever the response length.
    always_comb begin
        tx_byte     = 8'h00;
        rdata_shift = rdata_q << {idx_q[2:0], 2'b00};
        if (state_q == ST_RESP) begin
            if (idx_q == end_q) begin
                tx_byte = 8'h0A;
            end else if (idx_q == end_q - 4'd1) begin
                tx_byte = 8'h0D;
            end else begin
                case (resp_q)
                    RSP_OK:  tx_byte = idx_q[0] ? 8'h4B : 8'h4F;
                    RSP_ER:  tx_byte = idx_q[0] ? 8'h52 : 8'h45;
                    RSP_TO:  tx_byte = idx_q[0] ? 8'h4F : 8'h54;
                    default: tx_byte = nib_to_asc(rdata_shift[31:28]);
                endcase
            end
        end
    end

    // Next-state logic for the IDLE -> MEM -> RESP -> IDLE command flow.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned (which would infer a latch).
        state_d   = state_q;
        resp_d    = resp_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        idx_d     = idx_q;
        end_d     = end_q;
        overrun_d = overrun_q | (CMD_VALID && state_q != ST_IDLE);
`ifdef UART_EXEC_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    idx_d  = 4'd0;
                    end_d  = 4'd3;
                    resp_d = RSP_ER;
`ifdef UART_EXEC_TIMEOUT_EN
                    cnt_d  = 8'd0;
`endif
                    if (CMD_FAIL) begin
                        state_d = ST_RESP;
                    end else if (CMD_W || CMD_R) begin
                        state_d = ST_MEM;
                        we_d    = CMD_W;
                        addr_d  = cmd_addr;
                        wdata_d = cmd_wdata;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_MEM: begin
                if (MEM_ACK) begin
                    state_d = ST_RESP;
                    idx_d   = 4'd0;
                    if (we_q) begin
                        resp_d = RSP_OK;
                        end_d  = 4'd3;
                    end else begin
                        resp_d  = RSP_HEX;
                        end_d   = 4'd9;
                        rdata_d = MEM_RDATA;
                    end
                end
`ifdef UART_EXEC_TIMEOUT_EN
                // An acknowledge in the final counted cycle still wins.
                else if (cnt_q == 8'hFF) begin
                    state_d = ST_RESP;
                    idx_d   = 4'd0;
                    resp_d  = RSP_TO;
                    end_d   = 4'd3;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`else
                // Without the timeout, MEM waits indefinitely for MEM_ACK.
`endif
            end
            ST_RESP: begin
                if (TX_READY) begin
                    if (idx_q == end_q) state_d = ST_IDLE;
                    else                idx_d   = idx_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            state_q   <= ST_IDLE;
            resp_q    <= RSP_OK;
            we_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            idx_q     <= 4'd0;
            end_q     <= 4'd3;
            overrun_q <= 1'b0;
`ifdef UART_EXEC_TIMEOUT_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            resp_q    <= resp_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            idx_q     <= idx_d;
            end_q     <= end_d;
            overrun_q <= overrun_d;
`ifdef UART_EXEC_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign PARSER_START = (state_q == ST_IDLE);
    assign BUSY         = (state_q != ST_IDLE);
    assign MEM_REQ      = (state_q == ST_MEM);
    assign MEM_WE       = MEM_REQ && we_q;
    assign MEM_ADDR     = addr_q;
    assign MEM_WDATA    = wdata_q;
    assign TX_VALID     = (state_q == ST_RESP);
    assign TX_DATA      = tx_byte;
    assign OVERRUN      = overrun_q;

endmodule

// File: doc/uart_cmd_exec.md
# uart_cmd_exec

Command executor between the UART command parser and a 256 x 32-bit register/memory port. It accepts one parsed command per pulse, with ASCII-hex address and data. It converts the fields to binary, runs a single memory transaction with a req/ack handshake, and streams an ASCII response ("OK", "ER", "TO", or 8 hex digits, each followed by CR LF) to the UART transmitter. It also gates the parser's START input so that only one command is in flight at a time.

## Interface
- No parameters; widths are fixed: address 8 bits, data 32 bits, timeout 255 cycles.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  one-cycle command strobe (parser OUTPUT_DONE).
- CMD_W  in  1  write command.
- CMD_R  in  1  read command.
- CMD_FAIL  in  1  parser rejected the command.
- CMD_ADDR  in  16  two ASCII hex chars, MS char in [15:8].
- CMD_DATA  in  64  eight ASCII hex chars, MS char in [63:56].
- PARSER_START  out  1  enables the parser; high only in IDLE.
- MEM_REQ  out  1  memory request; held until acknowledged.
- MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ is high.
- MEM_ADDR  out  8  binary address.
- MEM_WDATA  out  32  binary write data.
- MEM_ACK  in  1  one-cycle completion; for reads, MEM_RDATA is valid in the same cycle.
- MEM_RDATA  in  32  read data.
- TX_VALID  out  1  a response byte is available.
- TX_DATA  out  8  response byte.
- TX_READY  in  1  transmitter accepts the byte when TX_VALID && TX_READY.
- BUSY  out  1  high in any state other than IDLE.
- OVERRUN  out  1  sticky: CMD_VALID arrived while BUSY; cleared only by RST.

## Operation
- Reset values: PARSER_START=1, all other outputs 0, state IDLE.
- States: IDLE, MEM, RESP.
- **IDLE.** On CMD_VALID, latch the command and choose the next state by priority:
  - CMD_FAIL=1: go to RESP with "ER\r\n".
  - Otherwise CMD_W=1: go to MEM with MEM_WE=1.
  - Otherwise CMD_R=1: go to MEM with MEM_WE=0.
  - No flag set: go to RESP with "ER\r\n".
- **ASCII to binary conversion.** 0x30–0x39 maps to c-0x30; 0x41–0x46 maps to c-0x37. Any other char maps to 0; the parser has already validated the fields. MEM_ADDR = {nib(CMD_ADDR[15:8]), nib(CMD_ADDR[7:0])}. MEM_WDATA is built the same way, MS nibble first.
- **MEM.** MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA are held stable until MEM_ACK.
  - On MEM_ACK: MEM_REQ drops on the next edge and the FSM goes to RESP.
  - A write responds "OK\r\n".
  - A read captures MEM_RDATA and responds with 8 hex chars plus "\r\n" (10 bytes).
- **Hex encoding.** Nibble 0–9 maps to 0x30+n; A–F maps to 0x37+n (uppercase). MS nibble is sent first.
- **RESP.** A 4-bit index selects the byte and an end index is latched (3 or 9).
  - TX_VALID stays high with TX_DATA stable until the handshake.
  - After each handshake the index increments.
  - The handshake on the last byte returns the FSM to IDLE and clears TX_VALID.
- **Overrun.** CMD_VALID while not in IDLE is ignored and sets OVERRUN. MEM and RESP are unaffected.
- **Reset mid-operation.** RST in any state goes to IDLE on the next edge. MEM_REQ and TX_VALID drop immediately; a partial response is abandoned.

## Timing
- CMD_VALID at edge N: BUSY=1 and PARSER_START=0 at N+1. MEM_REQ=1 at N+1, or TX_VALID=1 at N+1 for error commands.
- MEM_ACK at edge M: MEM_REQ=0 and TX_VALID=1 (first response byte) at M+1.
- MEM_ACK in the same cycle that MEM_REQ first rises is legal and counts as an acknowledge.
- With TX_READY tied high, one byte is sent per cycle. A 10-byte read response occupies 10 cycles, then IDLE on the edge after the last handshake.
- PARSER_START returns to 1 in the same cycle the FSM re-enters IDLE, so a new command can be accepted one cycle after the final handshake.
- MEM_ACK outside MEM is ignored. TX_READY without TX_VALID has no effect.

## Configuration
- UART_EXEC_TIMEOUT_EN defined:
  - An 8-bit counter runs in MEM, clearing on entry.
  - If it reaches 255 without MEM_ACK, MEM_REQ drops on the next edge and the response is "TO\r\n".
  - A MEM_ACK arriving in that same cycle wins, and the normal response is sent.
- Undefined: no counter; MEM waits indefinitely for MEM_ACK.

## Test plan
- Write "W 3A 1234ABCD": MEM_REQ=1, MEM_WE=1, MEM_ADDR=0x3A, MEM_WDATA=0x1234ABCD; ACK after 3 cycles; TX bytes 0x4F 0x4B 0x0D 0x0A; PARSER_START returns to 1.
- Read "R FF" with MEM_RDATA=0x00C0FFEE, TX_READY toggling 1/0: TX bytes "00C0FFEE\r\n" in order. Each byte is held stable while TX_READY=0.
- CMD_FAIL=1: no MEM_REQ; TX bytes 0x45 0x52 0x0D 0x0A.
- Second CMD_VALID during RESP: OVERRUN=1; the response completes unchanged; OVERRUN clears only on RST.
- RST asserted in MEM and at response byte 5: all outputs return to reset values on the next edge; a subsequent write completes normally.
- With UART_EXEC_TIMEOUT_EN and MEM_ACK never asserted: MEM_REQ drops after 255 cycles and TX sends "TO\r\n". Without the macro, MEM_REQ stays high for more than 1000 cycles.
